// File: rtl/seq_det_pkg.sv
// Shared defaults, mode encoding and sizing helper for the serial pattern detector.
// Used by seq_detector_param (optional SEQ_DET_PROG_EN build).
package seq_det_pkg;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_CNT_W   = 8;

  typedef enum logic {
    SEQ_NONOVL = 1'b0,
    SEQ_OVL    = 1'b1
  } seq_mode_e;

  // Fill must be able to hold the value PAT_W itself, hence the +1.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Generic saturating up-counter with synchronous clear; a clear and an increment
// on the same edge yield a count of one.
module seq_det_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;

  // NOTE: registered state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised valid-qualified serial pattern detector with saturating match count.
// Define SEQ_DET_PROG_EN to add a run-time loadable pattern (pat_load/pat_value).
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               OVERLAP = 0,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             data_in,
  input  logic             cnt_clr,
`ifdef SEQ_DET_PROG_EN
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
`endif
  output logic             pat_dec,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam seq_mode_e         MODE      = (OVERLAP != 0) ? SEQ_OVL : SEQ_NONOVL;

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  shifted;
  logic [PAT_W-1:0]  pat_act;
  logic [FILL_W-1:0] fill;
  logic              load;
  logic              hit;

`ifdef SEQ_DET_PROG_EN
  logic [PAT_W-1:0] pat_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg <= PATTERN;
    end else if (pat_load) begin
      pat_reg <= pat_value;
    end
  end

  assign load    = pat_load;
  assign pat_act = pat_reg;
`else
  assign load    = 1'b0;
  assign pat_act = PATTERN;
`endif

  // NOTE: every combinational output gets an unconditional assignment, so no
  // latch can be inferred.
  always_comb begin
    shifted = {hist[PAT_W-2:0], data_in};
    hit     = valid && !load && (shifted == pat_act) && (fill >= FILL_LAST);
  end

  // NOTE: reset is synchronous and takes priority over load, valid and clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist    <= '0;
      fill    <= '0;
      pat_dec <= 1'b0;
    end else begin
      pat_dec <= hit;
      if (load) begin
        hist <= '0;
        fill <= '0;
      end else if (valid) begin
        hist <= shifted;
        // A non-overlapping hit consumes its bits; overlap keeps fill saturated.
        if (hit && (MODE == SEQ_NONOVL)) begin
          fill <= '0;
        end else if (fill != FILL_MAX) begin
          fill <= fill + FILL_W'(1);
        end
      end
    end
  end

  seq_det_sat_cnt #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (hit),
    .count(match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: a non-overlapping 8-bit-count detector and an overlapping
// 2-bit-count detector share one stimulus stream and are checked against a queue model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       data_in = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_value = 4'b0000;
  logic       pat_dec0, pat_dec1;
  logic [7:0] match_cnt0;
  logic [1:0] match_cnt1;

  int passed = 0;
  int total  = 0;

  // Reference model state: accepted bits since reset/load (and, non-overlap, since last hit).
  bit         q0[$];
  bit         q1[$];
  logic [3:0] pat_m = 4'b1011;
  int         cnt0_m = 0;
  int         cnt1_m = 0;
  bit         dec0_m = 1'b0;
  bit         dec1_m = 1'b0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .valid(valid), .data_in(data_in), .cnt_clr(cnt_clr),
`ifdef SEQ_DET_PROG_EN
    .pat_load(pat_load), .pat_value(pat_value),
`endif
    .pat_dec(pat_dec0), .match_cnt(match_cnt0)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .valid(valid), .data_in(data_in), .cnt_clr(cnt_clr),
`ifdef SEQ_DET_PROG_EN
    .pat_load(pat_load), .pat_value(pat_value),
`endif
    .pat_dec(pat_dec1), .match_cnt(match_cnt1)
  );

  function automatic bit model_hit(input bit q[$], input logic [3:0] p);
    logic [3:0] v = '0;
    if (q.size() != 4) return 1'b0;
    foreach (q[i]) v = {v[2:0], q[i]};
    return v == p;
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic d, input logic c,
                            input logic l, input logic [3:0] pv);
    bit h0 = 1'b0;
    bit h1 = 1'b0;
    if (r) begin
      q0.delete(); q1.delete();
      pat_m = 4'b1011; cnt0_m = 0; cnt1_m = 0; dec0_m = 1'b0; dec1_m = 1'b0;
      return;
    end
    if (l) begin
      pat_m = pv; q0.delete(); q1.delete();
    end else if (v) begin
      q0.push_back(d); if (q0.size() > 4) void'(q0.pop_front());
      q1.push_back(d); if (q1.size() > 4) void'(q1.pop_front());
      h0 = model_hit(q0, pat_m);
      h1 = model_hit(q1, pat_m);
      if (h0) q0.delete();
    end
    if (c) cnt0_m = int'(h0); else if (h0 && cnt0_m < 255) cnt0_m++;
    if (c) cnt1_m = int'(h1); else if (h1 && cnt1_m < 3) cnt1_m++;
    dec0_m = h0;
    dec1_m = h1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic v, input logic d, input logic c,
                      input logic l, input logic [3:0] pv);
    rst = r; valid = v; data_in = d; cnt_clr = c; pat_load = l; pat_value = pv;
    model_edge(r, v, d, c, l, pv);
    @(posedge clk);
    #1;
    check("pat_dec0", 32'(pat_dec0), 32'(dec0_m));
    check("match_cnt0", 32'(match_cnt0), 32'(cnt0_m));
    check("pat_dec1", 32'(pat_dec1), 32'(dec1_m));
    check("match_cnt1", 32'(match_cnt1), 32'(cnt1_m));
  endtask

  // Sends n bits MSB first; gaps inserts a valid=0 cycle with junk data before each bit.
  task automatic send(input logic [15:0] bits, input int n, input bit gaps, input bit clr_last);
    for (int i = 0; i < n; i++) begin
      if (gaps) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'b0000);
      step(1'b0, 1'b1, bits[n-1-i], clr_last && (i == n - 1), 1'b0, 4'b0000);
    end
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    check("reset_cnt0", 32'(match_cnt0), 32'd0);

    // Stream 1,0,1,1,0,1,1 back-to-back
    send(16'b1011011, 7, 1'b0, 1'b0);
    check("stream_cnt_nonovl", 32'(match_cnt0), 32'd1);
    check("stream_cnt_ovl", 32'(match_cnt1), 32'd2);

    // Same stream with idle cycles between bits
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    send(16'b1011011, 7, 1'b1, 1'b0);
    check("gap_cnt_nonovl", 32'(match_cnt0), 32'd1);
    check("gap_cnt_ovl", 32'(match_cnt1), 32'd2);

    // Reset in mid-pattern discards the partial match
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    send(16'b101, 3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    send(16'b1, 1, 1'b0, 1'b0);
    check("midrst_no_pulse", 32'(match_cnt0), 32'd0);
    send(16'b011, 3, 1'b0, 1'b0);
    check("midrst_fresh_cnt0", 32'(match_cnt0), 32'd1);
    check("midrst_fresh_cnt1", 32'(match_cnt1), 32'd1);

    // Saturation of the 2-bit count, then clear coinciding with a hit
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    send(16'b1011011011011, 13, 1'b0, 1'b0);
    check("sat_cnt1", 32'(match_cnt1), 32'd3);
    check("sat_cnt0", 32'(match_cnt0), 32'd2);
    send(16'b011, 3, 1'b0, 1'b1);
    check("clr_hit_cnt1", 32'(match_cnt1), 32'd1);
    check("clr_hit_cnt0", 32'(match_cnt0), 32'd1);

`ifdef SEQ_DET_PROG_EN
    // Pattern load mid-stream; the sample on the load edge is discarded
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    send(16'b101, 3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0110);
    send(16'b0110, 4, 1'b0, 1'b0);
    check("prog_hit_cnt0", 32'(match_cnt0), 32'd1);
    send(16'b1011, 4, 1'b0, 1'b0);
    check("prog_old_pat_cnt0", 32'(match_cnt0), 32'd1);
    check("prog_old_pat_cnt1", 32'(match_cnt1), 32'd1);
`endif

    // Randomized traffic against the model
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 600; i++) begin
      logic r, v, d, c, l;
      logic [3:0] pv;
      r  = ($urandom_range(0, 79) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 29) == 0);
      l  = 1'b0;
      pv = 4'($urandom_range(0, 15));
`ifdef SEQ_DET_PROG_EN
      l  = ($urandom_range(0, 59) == 0);
`endif
      step(r, v, d, c, l, pv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
